nonce_dispatcher: RTL and testbench

NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

---
 rtl/nonce_dispatcher.sv | 141 ++++++++++++++
 tb/tb_nonce_dispatcher.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : nonce_dispatcher
// Description : Hands nonces from a generator to a hash core one at a time
//               and compares each hash against a difficulty target.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_dispatcher #(
    parameter int HASH_W = 256
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [HASH_W-1:0] target,
    input  logic [31:0]       nonce_in,
    input  logic              overflow_in,
    output logic              gen_enable,
    output logic              gen_reset,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [31:0]       job_nonce,
    input  logic              hash_valid,
    input  logic [HASH_W-1:0] hash,
    output logic              busy,
    output logic              found,
    output logic [31:0]       found_nonce,
    output logic              exhausted,
    output logic [31:0]       hash_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESTART   = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_HASH = 3'd3,
        S_FOUND     = 3'd4,
        S_EXHAUSTED = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_inflight;
    logic        r_last;
    logic [31:0] r_found_nonce;
    logic [31:0] r_hash_count;
    logic        w_xfer;
    logic        w_result;
    logic        w_hit;
    logic        w_launch;

    assign w_hit = (hash < target);

    always_comb begin
        w_next     = r_state;
        job_valid  = 1'b0;
        job_nonce  = 32'd0;
        gen_enable = 1'b0;
        gen_reset  = 1'b0;
        w_xfer     = 1'b0;
        w_result   = 1'b0;
        w_launch   = 1'b0;
        case (r_state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    w_next   = S_RESTART;
                    w_launch = 1'b1;
                end
            end
            S_RESTART: begin
                gen_reset = 1'b1;
                w_next    = S_ISSUE;
            end
            S_ISSUE: begin
                job_nonce = nonce_in;
                job_valid = 1'b1;
                if (job_ready) begin
                    gen_enable = 1'b1;
                    w_xfer     = 1'b1;
                    w_next     = S_WAIT_HASH;
                end
            end
            S_WAIT_HASH: begin
                if (hash_valid) begin
                    w_result = 1'b1;
                    if (w_hit)
                        w_next = S_FOUND;
                    else if (r_last)
                        w_next = S_EXHAUSTED;
                    else
                        w_next = S_ISSUE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Abort overrides everything decided above in the same cycle.
        if (abort) begin
            w_next     = S_IDLE;
            job_valid  = 1'b0;
            gen_enable = 1'b0;
            w_xfer     = 1'b0;
            w_result   = 1'b0;
            w_launch   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_inflight    <= 32'd0;
            r_last        <= 1'b0;
            r_found_nonce <= 32'd0;
            r_hash_count  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_hash_count  <= 32'd0;
                r_found_nonce <= 32'd0;
            end
            if (w_xfer) begin
                r_inflight <= nonce_in;
                r_last     <= overflow_in;
            end
            if (w_result) begin
                if (r_hash_count != 32'hFFFF_FFFF)
                    r_hash_count <= r_hash_count + 32'd1;
                if (w_hit)
                    r_found_nonce <= r_inflight;
            end
        end
    end

    assign busy        = (r_state == S_RESTART) || (r_state == S_ISSUE) ||
                         (r_state == S_WAIT_HASH);
    assign found       = (r_state == S_FOUND);
    assign exhausted   = (r_state == S_EXHAUSTED);
    assign found_nonce = r_found_nonce;
    assign hash_count  = r_hash_count;

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_dispatcher
// Description : Scoreboard bench with generator and hash-core models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_dispatcher;

    localparam int HASH_W = 256;

    logic              clk = 1'b0;
    logic              n_rst, start, abort, overflow_in, job_ready, hash_valid;
    logic [HASH_W-1:0] target, hash;
    logic [31:0]       nonce_in, job_nonce, found_nonce, hash_count;
    logic              gen_enable, gen_reset, job_valid, busy, found, exhausted;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_gen_en = 0;
    int          n_gen_rst = 0;
    int          lat = 1;
    int          mode = 0;
    logic [31:0] gen_max = 32'd1024;
    logic [31:0] gen_nonce = 32'd0;
    logic [31:0] exp_q[$];

    logic        pend = 1'b0;
    logic [31:0] pnonce = 32'd0;
    int          cd = 0;

    nonce_dispatcher #(.HASH_W(HASH_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .target(target), .nonce_in(nonce_in), .overflow_in(overflow_in),
        .gen_enable(gen_enable), .gen_reset(gen_reset), .job_valid(job_valid),
        .job_ready(job_ready), .job_nonce(job_nonce), .hash_valid(hash_valid),
        .hash(hash), .busy(busy), .found(found), .found_nonce(found_nonce),
        .exhausted(exhausted), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    function automatic logic [HASH_W-1:0] hfn(input logic [31:0] n);
        case (mode)
            1:       hfn = (n == 32'd5) ? 256'd1 : {HASH_W{1'b1}};
            2:       hfn = target;
            default: hfn = {HASH_W{1'b1}};
        endcase
    endfunction

    // Nonce generator model
    assign nonce_in    = gen_nonce;
    assign overflow_in = (gen_nonce == gen_max);
    always @(posedge clk) begin
        if (gen_reset)
            gen_nonce <= 32'd0;
        else if (gen_enable)
            gen_nonce <= gen_nonce + 32'd1;
    end

    // Hash core model: result lat cycles after each accepted job
    always @(posedge clk) begin
        hash_valid <= 1'b0;
        if (pend) begin
            if (cd == 0) begin
                hash_valid <= 1'b1;
                hash       <= hfn(pnonce);
                pend       <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
        if (job_valid && job_ready) begin
            pend   <= 1'b1;
            pnonce <= job_nonce;
            cd     <= lat - 1;
        end
    end

    // Scoreboard: every accepted job must match the next expected nonce
    always @(negedge clk) begin
        if (n_rst && job_valid && job_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL job_nonce: unexpected job nonce=%0d, none expected", job_nonce);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (job_nonce !== e) begin
                    n_fail++;
                    $display("FAIL job_nonce: got %0d expected %0d", job_nonce, e);
                end
            end
        end
        if (gen_enable) n_gen_en++;
        if (gen_reset)  n_gen_rst++;
    end

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(i[31:0]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (found || exhausted) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_done: no found/exhausted within %0d cycles", budget);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"},        {31'd0, busy},        32'd0);
        chk({tag, " found"},       {31'd0, found},       32'd0);
        chk({tag, " exhausted"},   {31'd0, exhausted},   32'd0);
        chk({tag, " job_valid"},   {31'd0, job_valid},   32'd0);
        chk({tag, " gen_enable"},  {31'd0, gen_enable},  32'd0);
        chk({tag, " gen_reset"},   {31'd0, gen_reset},   32'd0);
        chk({tag, " job_nonce"},   job_nonce,            32'd0);
        chk({tag, " found_nonce"}, found_nonce,          32'd0);
        chk({tag, " hash_count"},  hash_count,           32'd0);
    endtask

    task automatic test_reset();
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic test_exhaust();
        mode = 0; gen_max = 32'd1024; lat = 1;
        n_gen_rst = 0; n_gen_en = 0;
        push_range(0, 1024);
        pulse_start();
        wait_done(10000);
        chk("exhaust exhausted", {31'd0, exhausted}, 32'd1);
        chk("exhaust found", {31'd0, found}, 32'd0);
        chk("exhaust hash_count", hash_count, 32'd1025);
        chk("exhaust gen_enable count", n_gen_en, 32'd1025);
        chk("exhaust gen_reset count", n_gen_rst, 32'd1);
        chk("exhaust queue left", exp_q.size(), 32'd0);
    endtask

    task automatic test_found();
        mode = 1; gen_max = 32'd1024; lat = 1;
        n_gen_en = 0;
        push_range(0, 5);
        pulse_start();
        wait_done(200);
        chk("found found", {31'd0, found}, 32'd1);
        chk("found found_nonce", found_nonce, 32'd5);
        chk("found hash_count", hash_count, 32'd6);
        chk("found gen_enable count", n_gen_en, 32'd6);
        chk("found queue left", exp_q.size(), 32'd0);
        repeat (5) @(negedge clk);
        chk("found hold", {31'd0, found}, 32'd1);
        chk("found hold nonce", found_nonce, 32'd5);
    endtask

    task automatic test_ready_stall();
        logic [31:0] n;
        int bad, ge;
        bit seen;
        mode = 1; lat = 1; job_ready = 1'b0;
        push_range(0, 5);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (job_valid) begin seen = 1'b1; break; end
        end
        chk("stall job_valid seen", {31'd0, seen}, 32'd1);
        n = job_nonce; bad = 0; ge = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!job_valid || job_nonce !== n) bad++;
            if (gen_enable) ge++;
        end
        chk("stall first nonce", n, 32'd0);
        chk("stall unstable cycles", bad, 32'd0);
        chk("stall gen_enable pulses", ge, 32'd0);
        @(posedge clk); #1 job_ready = 1'b1;
        wait_done(200);
        chk("stall found_nonce", found_nonce, 32'd5);
        chk("stall queue left", exp_q.size(), 32'd0);
    endtask

    task automatic test_equal();
        mode = 2; gen_max = 32'd3; lat = 2;
        push_range(0, 3);
        pulse_start();
        wait_done(200);
        chk("equal found", {31'd0, found}, 32'd0);
        chk("equal exhausted", {31'd0, exhausted}, 32'd1);
        chk("equal hash_count", hash_count, 32'd4);
        chk("equal queue left", exp_q.size(), 32'd0);
    endtask

    task automatic test_abort();
        int xfers;
        mode = 0; gen_max = 32'd1024; lat = 6;
        push_range(0, 1);
        pulse_start();
        xfers = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (job_valid && job_ready) xfers++;
            if (xfers == 2) break;
        end
        chk("abort transfers", xfers, 32'd2);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("abort job_valid", {31'd0, job_valid}, 32'd0);
        @(posedge clk); #1 abort = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort found", {31'd0, found}, 32'd0);
        chk("abort hash_count held", hash_count, 32'd1);
        chk("abort queue left", exp_q.size(), 32'd0);
        mode = 1; lat = 1; n_gen_rst = 0;
        push_range(0, 5);
        pulse_start();
        wait_done(200);
        chk("abort restart found_nonce", found_nonce, 32'd5);
        chk("abort restart hash_count", hash_count, 32'd6);
        chk("abort restart gen_reset count", n_gen_rst, 32'd1);
        chk("abort restart queue left", exp_q.size(), 32'd0);
    endtask

    task automatic test_reset_found();
        @(posedge clk); #1 n_rst = 1'b0;
        #1 check_reset_outputs("reset_found");
        @(posedge clk); #1 n_rst = 1'b1;
    endtask

    task automatic test_abort_start();
        bit seen;
        job_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (job_valid) begin seen = 1'b1; break; end
        end
        chk("abort_start issue seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1 abort = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_start job_valid", {31'd0, job_valid}, 32'd0);
        chk("abort_start gen_enable", {31'd0, gen_enable}, 32'd0);
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_start busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_start stays idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic test_reset_issue();
        bit seen;
        job_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (job_valid) begin seen = 1'b1; break; end
        end
        chk("reset_issue issue seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1 n_rst = 1'b0;
        #1 check_reset_outputs("reset_issue");
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_issue idle", {31'd0, busy}, 32'd0);
        job_ready = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; job_ready = 1'b1;
        target = 256'd1 << 255;
        test_reset();
        test_exhaust();
        test_found();
        test_ready_stall();
        test_equal();
        test_abort();
        test_reset_found();
        test_abort_start();
        test_reset_issue();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
